// File: rtl/chip_select_pkg.sv
// +----------------------------------------------------------------------+
// | chip_select_pkg : shared widths, FSM state type and reset pointer    |
// | for the chip-select arbiter.                                         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package chip_select_pkg;

  localparam int NUM_CS = 8;
  localparam int SEL_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  // Pointer starts at the top index so requester 0 wins first after reset.
  localparam logic [SEL_W-1:0] LAST_PTR_RST = 3'd7;

endpackage

`default_nettype wire

// File: rtl/rr_picker.sv
// +----------------------------------------------------------------------+
// | rr_picker : combinational round-robin selection, scanning upward    |
// | from last_ptr+1 with wrap-around.                                    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_picker
  import chip_select_pkg::*;
(
  input  logic [NUM_CS-1:0] i_req,
  input  logic [SEL_W-1:0]  i_last_ptr,
  output logic [SEL_W-1:0]  o_winner,
  output logic              o_any_req
);

  logic             w_found;
  logic [SEL_W-1:0] w_idx;

  // Offset 8 wraps back onto last_ptr itself, so it is tried last.
  always_comb begin
    o_winner = '0;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int i = 1; i <= NUM_CS; i++) begin
      w_idx = i_last_ptr + SEL_W'(i);
      if (!w_found && i_req[w_idx]) begin
        o_winner = w_idx;
        w_found  = 1'b1;
      end
    end
  end

  assign o_any_req = |i_req;

endmodule

`default_nettype wire

// File: rtl/chip_select_arbiter.sv
// +----------------------------------------------------------------------+
// | chip_select_arbiter : round-robin arbiter driving 8 active-low chip |
// | selects with a one-cycle break-before-make gap between grantees.    |
// | Optional hold limit enabled by macro CSA_HOLD_LIMIT_EN.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module chip_select_arbiter
  import chip_select_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [NUM_CS-1:0] req_i,
  output logic [NUM_CS-1:0] cs_n_o,
  output logic [SEL_W-1:0]  sel_o,
  output logic              enable_o,
  output logic              busy_o
);

  state_t            r_state, w_state_next;
  logic [SEL_W-1:0]  r_winner, w_winner_next;
  logic [SEL_W-1:0]  r_last_ptr, w_last_ptr_next;
  logic [SEL_W-1:0]  w_pick;
  logic              w_any_req;
  logic              w_hold_done;
  logic [NUM_CS-1:0] w_cs_n_next;
  logic [SEL_W-1:0]  w_sel_next;
  logic              w_enable_next;
  logic              w_busy_next;

  rr_picker u_rr_picker (
    .i_req      (req_i),
    .i_last_ptr (r_last_ptr),
    .o_winner   (w_pick),
    .o_any_req  (w_any_req)
  );

`ifdef CSA_HOLD_LIMIT_EN
  localparam logic [7:0] c_hold_last = 8'(MAX_HOLD - 1);
  logic [7:0] r_hold;

  // Cleared on every GRANT entry; saturates rather than wrapping.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_hold <= 8'd0;
    end else if (w_state_next == ST_GRANT && r_state != ST_GRANT) begin
      r_hold <= 8'd0;
    end else if (r_state == ST_GRANT && r_hold != 8'hFF) begin
      r_hold <= r_hold + 8'd1;
    end
  end

  assign w_hold_done = (r_hold == c_hold_last);
`else
  logic [7:0] w_unused_max_hold;
  assign w_unused_max_hold = 8'(MAX_HOLD);
  assign w_hold_done       = 1'b0;
`endif

  // State and all outputs are registered so reset can clear them asynchronously.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= ST_IDLE;
      r_winner   <= '0;
      r_last_ptr <= LAST_PTR_RST;
      cs_n_o     <= '1;
      sel_o      <= '0;
      enable_o   <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_winner   <= w_winner_next;
      r_last_ptr <= w_last_ptr_next;
      cs_n_o     <= w_cs_n_next;
      sel_o      <= w_sel_next;
      enable_o   <= w_enable_next;
      busy_o     <= w_busy_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_winner_next   = r_winner;
    w_last_ptr_next = r_last_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_state_next  = ST_GRANT;
          w_winner_next = w_pick;
        end
      end
      ST_GRANT: begin
        if (!req_i[r_winner] || w_hold_done) begin
          w_state_next    = ST_RELEASE;
          w_last_ptr_next = r_winner;
        end
      end
      ST_RELEASE: begin
        if (w_any_req) begin
          w_state_next  = ST_GRANT;
          w_winner_next = w_pick;
        end else begin
          w_state_next  = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state and captured with it.
  always_comb begin
    w_cs_n_next   = '1;
    w_enable_next = 1'b0;
    w_sel_next    = w_winner_next;
    w_busy_next   = (w_state_next != ST_IDLE);
    if (w_state_next == ST_GRANT) begin
      w_cs_n_next   = ~(NUM_CS'(1) << w_winner_next);
      w_enable_next = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_chip_select_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_chip_select_arbiter : randomized and directed self-checking bench |
// | against an owner/gap reference model of the arbiter.                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_chip_select_arbiter;

  localparam int TB_MAX_HOLD = 4;

  logic       clk_i;
  logic       rst_n_i;
  logic [7:0] req_i;
  logic [7:0] cs_n_o;
  logic [2:0] sel_o;
  logic       enable_o;
  logic       busy_o;

  int n_cmp;
  int n_fail;

  // Reference model: who owns the bus, for how many cycles, and whether
  // the current cycle is the handover gap.
  int m_owner;
  int m_held;
  int m_last;
  bit m_gap;

  chip_select_arbiter #(.MAX_HOLD(TB_MAX_HOLD)) dut (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .req_i    (req_i),
    .cs_n_o   (cs_n_o),
    .sel_o    (sel_o),
    .enable_o (enable_o),
    .busy_o   (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Invariants: at most one select low; enable tracks any select low.
  always @(negedge clk_i) begin
    if (rst_n_i) begin
      n_cmp++;
      assert ($countones(~cs_n_o) <= 1 && (enable_o == (cs_n_o != 8'hFF))) else begin
        n_fail++;
        $display("FAIL invariant: cs_n_o=%h enable_o=%b required one-hot-or-none and matching enable",
                 cs_n_o, enable_o);
      end
    end
  end

  task automatic model_reset();
    m_owner = -1;
    m_held  = 0;
    m_last  = 7;
    m_gap   = 1'b0;
  endtask

  task automatic model_edge(input logic [7:0] r);
    bit hold_en;
`ifdef CSA_HOLD_LIMIT_EN
    hold_en = 1'b1;
`else
    hold_en = 1'b0;
`endif
    if (m_owner >= 0) begin
      m_held++;
      if (!r[m_owner] || (hold_en && m_held == TB_MAX_HOLD)) begin
        m_last  = m_owner;
        m_owner = -1;
        m_gap   = 1'b1;
      end
    end else begin
      m_gap = 1'b0;
      for (int k = 1; k <= 8; k++) begin
        if (m_owner < 0 && r[(m_last + k) % 8]) begin
          m_owner = (m_last + k) % 8;
          m_held  = 0;
        end
      end
    end
  endtask

  // Drive one request vector, let one edge pass, then compare against the model.
  task automatic cycle(input logic [7:0] r, input string tag);
    logic [7:0] exp_cs;
    req_i = r;
    @(posedge clk_i);
    model_edge(r);
    #1;
    exp_cs = (m_owner >= 0) ? ~(8'h01 << m_owner) : 8'hFF;
    n_cmp++;
    if (cs_n_o !== exp_cs || enable_o !== (m_owner >= 0) ||
        busy_o !== (m_owner >= 0 || m_gap) ||
        (m_owner >= 0 && sel_o !== 3'(m_owner))) begin
      n_fail++;
      $display("FAIL %s: cs_n_o=%h en=%b busy=%b sel=%0d, required cs_n_o=%h en=%b busy=%b sel=%0d",
               tag, cs_n_o, enable_o, busy_o, sel_o, exp_cs, (m_owner >= 0),
               (m_owner >= 0 || m_gap), m_owner);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk_i);
    rst_n_i = 1'b0;
    req_i   = 8'h00;
    model_reset();
    #1;
    n_cmp++;
    if (cs_n_o !== 8'hFF || sel_o !== 3'd0 || enable_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: cs_n_o=%h sel=%0d en=%b busy=%b, required FF 0 0 0",
               cs_n_o, sel_o, enable_o, busy_o);
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    cycle(8'h00, "idle_after_reset");
  endtask

  task automatic test_single();
    apply_reset();
    for (int i = 0; i < 3; i++) cycle(8'h01, "single_grant");
    for (int i = 0; i < 3; i++) cycle(8'h00, "single_release");
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int i = 0; i < 3; i++) cycle(8'h81, "b2b_first");
    for (int i = 0; i < 4; i++) cycle(8'h80, "b2b_switch");
    cycle(8'h00, "b2b_drop");
    cycle(8'h00, "b2b_idle");
  endtask

  task automatic test_hold_limit();
    apply_reset();
    for (int i = 0; i < 45; i++) cycle(8'hFF, "hold_all_req");
    cycle(8'h00, "hold_drop");
    cycle(8'h00, "hold_idle");
  endtask

  task automatic test_glitch();
    apply_reset();
    cycle(8'h00, "glitch_pre");
    req_i = 8'h04;
    #2;
    req_i = 8'h00;
    cycle(8'h00, "glitch_not_granted");
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 0; i < 3; i++) cycle(8'h20, "grant_idx5");
    #3;
    rst_n_i = 1'b0;
    #1;
    n_cmp++;
    if (cs_n_o !== 8'hFF || enable_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: cs_n_o=%h en=%b busy=%b, required FF 0 0 before edge",
               cs_n_o, enable_o, busy_o);
    end
    model_reset();
    req_i = 8'h00;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    for (int i = 0; i < 2; i++) cycle(8'h21, "after_reset_prio0");
    cycle(8'h20, "after_reset_next5");
    cycle(8'h20, "after_reset_hold5");
    cycle(8'h00, "after_reset_drop");
  endtask

  task automatic test_random();
    logic [7:0] r;
    apply_reset();
    r = 8'h00;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(3, 0) == 0) r = 8'($urandom);
      if ($urandom_range(9, 0) == 0) r = 8'h00;
      cycle(r, "random");
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    rst_n_i = 1'b0;
    req_i   = 8'h00;
    model_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_hold_limit();
    test_glitch();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/chip_select_arbiter.md
CHIP_SELECT_ARBITER -- requirements
Module: chip_select_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 16: maximum consecutive GRANT cycles per grant; legal range 1..255.
REQ-002 clk_i  input  1  single system clock; all state changes on rising edge.
REQ-003 rst_n_i  input  1  reset, asynchronous, active-low.
REQ-004 req_i  input  8  level request per peripheral; bit n requests chip select n.
REQ-005 cs_n_o  output  8  registered active-low one-hot chip selects (3-to-8 decoder output format); all-ones when none granted.
REQ-006 sel_o  output  3  registered binary index of current grantee; valid only while enable_o=1.
REQ-007 enable_o  output  1  registered active-high decoder enable; 1 only in GRANT.
REQ-008 busy_o  output  1  registered; 1 whenever state is not IDLE.

Function
REQ-009 FSM states SHALL be IDLE, GRANT, RELEASE.
REQ-010 IDLE: req_i==0 -> stay; any req_i bit set -> GRANT, latching the winner.
REQ-011 Winner: first set req_i bit scanning upward from last_ptr+1, wrapping 7->0 (round-robin).
REQ-012 GRANT: cs_n_o[winner]=0, all other bits 1, sel_o=winner, enable_o=1; hold counter increments each cycle.
REQ-013 GRANT exit: req_i[winner]==0 sampled -> RELEASE; other req_i bits are ignored while in GRANT.
REQ-014 RELEASE: one cycle, cs_n_o=8'hFF, enable_o=0 (break-before-make); last_ptr <= winner on entry.
REQ-015 RELEASE exit: any req_i set -> GRANT with new winner (using updated last_ptr); else IDLE.
REQ-016 Latency: request sampled in IDLE at edge k -> cs_n_o asserted after edge k (1 cycle); minimum grant 1 cycle.
REQ-017 Requester-to-requester switchover SHALL be exactly one dead cycle (RELEASE).
REQ-018 Request asserted and withdrawn before sampling SHALL not be granted; glitch-free outputs (all registered).
REQ-019 cs_n_o SHALL never have more than one bit low in any cycle.
REQ-020 Hold counter is 8 bits, cleared on every GRANT entry; it never wraps.

Reset
REQ-021 rst_n_i low SHALL immediately force: state=IDLE, cs_n_o=8'hFF, sel_o=0, enable_o=0, busy_o=0, hold counter=0, last_ptr=7 (req 0 highest priority after reset).
REQ-022 Reset asserted mid-GRANT SHALL deassert the chip select asynchronously, without waiting for a clock edge.
REQ-023 First edge after reset release SHALL behave as IDLE.

Configuration
REQ-024 Macro CSA_HOLD_LIMIT_EN defined: GRANT also exits to RELEASE when hold counter reaches MAX_HOLD-1 (grant lasts at most MAX_HOLD cycles), even if req_i[winner] remains 1.
REQ-025 CSA_HOLD_LIMIT_EN undefined: no hold limit; grant lasts until req_i[winner] drops; the hold counter and the MAX_HOLD logic are absent.

Structure
REQ-026 Shared package chip_select_pkg SHALL hold NUM_CS=8, SEL_W=3, the FSM state enum type, and the reset value of last_ptr.
REQ-027 Combinational round-robin pick (req vector + last_ptr -> winner index + any_req) SHALL be a sub-module named rr_picker, instantiated once.

Verification
REQ-028 Reset then req_i=8'h01 held 3 cycles then dropped -> cs_n_o=8'hFE one cycle after sampling, for 3 cycles, then 8'hFF; sel_o=0.
REQ-029 req_i=8'h81 held from IDLE after reset -> grant 0 first; after req_i[0] drops: one RELEASE cycle (cs_n_o=8'hFF), then cs_n_o=8'h7F, sel_o=7.
REQ-030 req_i=8'hFF continuous, CSA_HOLD_LIMIT_EN defined, MAX_HOLD=4 -> grants 0,1,2,...,7,0 in order, each 4 cycles, separated by single 8'hFF cycles.
REQ-031 Same stimulus, CSA_HOLD_LIMIT_EN undefined -> grant 0 held indefinitely; cs_n_o stays 8'hFE.
REQ-032 rst_n_i pulsed low mid-GRANT of index 5 -> cs_n_o=8'hFF before next clock edge; after release, req_i=8'h21 grants index 0 first.
REQ-033 All scenarios: assertion that cs_n_o has at most one zero bit, and that enable_o==1 exactly when cs_n_o != 8'hFF.
